clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_S, default 10: tick_i strobes with no button press before the block abandons set mode.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port tick_i, input, 1: one-cycle 1 Hz strobe; drives timeout and blink.
REQ-005 SHALL have port btn_mode_i, input, 1: one-cycle, debounced, synchronous press pulse; advances mode.
REQ-006 SHALL have port btn_inc_i, input, 1: one-cycle press pulse; increments the selected field.
REQ-007 SHALL have ports hours_cur_i [4:0], mins_cur_i [5:0], secs_cur_i [5:0], input: live time from the timekeeper.
REQ-008 SHALL have port ld_o, output, 1: one-cycle load strobe to the timekeeper start input.
REQ-009 SHALL have ports hours_o [4:0], mins_o [5:0], secs_o [5:0], output: shadow time, valid while ld_o=1.
REQ-010 SHALL have port mode_o, output, 2: 0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC.
REQ-011 SHALL have port blink_o, output, 1: display blanking for the selected field.

Function
REQ-012 SHALL implement states RUN, SET_HR, SET_MIN, SET_SEC and COMMIT.
REQ-013 In RUN, btn_mode_i SHALL capture the *_cur_i inputs into the shadow registers and move to SET_HR on the same edge.
REQ-014 On capture, any out-of-range value SHALL be stored as 0: hours >23, minutes >59, seconds >59.
REQ-015 btn_mode_i SHALL advance the state SET_HR->SET_MIN->SET_SEC->COMMIT.
REQ-016 COMMIT SHALL last exactly one cycle with ld_o=1, then go to RUN; ld_o SHALL be 0 in every other state.
REQ-017 btn_inc_i in SET_x SHALL add 1 to the selected field, wrapping at the maximum: hours 23->0, minutes 59->0, seconds 59->0.
REQ-018 The new field value SHALL be visible on the output one cycle after the press.
REQ-019 btn_inc_i SHALL be ignored in RUN and in COMMIT.
REQ-020 If btn_mode_i and btn_inc_i are high together, mode SHALL win and inc SHALL be discarded.
REQ-021 An inactivity counter SHALL clear on any button pulse and on entering set mode, and SHALL count tick_i strobes while in a SET_x state.
REQ-022 When the inactivity counter reaches TIMEOUT_S, the block SHALL return to RUN without a load, and the shadow values SHALL be discarded.
REQ-023 If a timeout and a button pulse coincide, the button SHALL take precedence.
REQ-024 blink_o SHALL toggle on each tick_i in SET_x states and SHALL be 0 in RUN and COMMIT.
REQ-025 blink_o SHALL be forced to 0 on the cycle after any increment, so the edited field stays visible.
REQ-026 In RUN, hours_o, mins_o and secs_o SHALL hold their last values.
REQ-027 mode_o SHALL read 3 during COMMIT.

Reset
REQ-028 Asserting reset SHALL immediately force state RUN, set ld_o, blink_o and mode_o to 0, and clear the shadow registers and the inactivity counter.
REQ-029 Reset asserted mid-edit SHALL abort the edit, with no ld_o pulse before or after reset.

Configuration
REQ-030 When CLOCK_SET_DEC_EN is defined, the block SHALL add input btn_dec_i (1 bit) with the following behaviour:
- in SET_x, btn_dec_i decrements the selected field, wrapping 0->23 for hours and 0->59 for minutes/seconds;
- inc and dec together leave the field unchanged but still clear the inactivity counter;
- mode beats dec.
REQ-031 When CLOCK_SET_DEC_EN is undefined, btn_dec_i SHALL NOT exist and only increment SHALL be possible.

Structure
REQ-032 Shared package clock_pkg SHALL hold:
- the state enum;
- HOURS_MAX=23, MINS_MAX=59, SECS_MAX=59;
- field widths HOURS_W=5, MINS_W=6.
REQ-033 Per-field wrap logic SHALL be sub-module field_adj:
- parameters width and max;
- inputs inc and dec;
- output the next value.
REQ-034 clock_set_ctrl SHALL instantiate field_adj three times.

Verification
REQ-035 Reset -> state RUN, all outputs 0; then mode press with cur=13:45:07 -> mode_o=1 and shadow=13:45:07.
REQ-036 SET_HR with hours=23, inc -> hours_o=0; SET_MIN with mins=59, inc -> mins_o=0, with hours unchanged.
REQ-037 Four mode presses from RUN -> exactly one ld_o pulse, carrying the edited values, with mode_o=3 that cycle; then RUN.
REQ-038 Idle in SET_MIN for 10 ticks -> return to RUN, no ld_o; an inc on the 10th tick -> stay in SET_MIN, field +1.
REQ-039 Capture with cur hours=24 -> shadow hours=0; mode and inc in the same cycle -> state advances, field unchanged.
REQ-040 Reset mid-SET_SEC -> RUN, no ld_o; with CLOCK_SET_DEC_EN, dec at secs=0 -> 59.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and field limits for the clock set-mode controller and its field adjusters.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  localparam int HOURS_MAX = 23;
  localparam int MINS_MAX  = 59;
  localparam int SECS_MAX  = 59;

  localparam int HOURS_W = 5;
  localparam int MINS_W  = 6;
  localparam int SECS_W  = 6;

  // Externally visible mode code; COMMIT still reports the seconds field.
  function automatic logic [1:0] mode_code(input state_t s);
    case (s)
      RUN:     return 2'd0;
      SET_HR:  return 2'd1;
      SET_MIN: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic is_set(input state_t s);
    return (s == SET_HR) || (s == SET_MIN) || (s == SET_SEC);
  endfunction

endpackage

// File: rtl/field_adj.sv
// Wrapping +1/-1 adjuster for one time field; inc and dec together leave the value unchanged.
module field_adj #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic [WIDTH-1:0] value,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] next_value
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);

  always_comb begin
    next_value = value;
    if (inc && !dec) begin
      next_value = (value >= TOP) ? '0 : value + 1'b1;
    end else if (dec && !inc) begin
      next_value = ((value == '0) || (value > TOP)) ? TOP : value - 1'b1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode controller for a HH:MM:SS clock: captures live time, edits it field by field, loads it back.
// Optional decrement button is enabled by defining CLOCK_SET_DEC_EN.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_i,
  input  logic               btn_mode_i,
  input  logic               btn_inc_i,
`ifdef CLOCK_SET_DEC_EN
  input  logic               btn_dec_i,
`endif
  input  logic [HOURS_W-1:0] hours_cur_i,
  input  logic [MINS_W-1:0]  mins_cur_i,
  input  logic [SECS_W-1:0]  secs_cur_i,
  output logic               ld_o,
  output logic [HOURS_W-1:0] hours_o,
  output logic [MINS_W-1:0]  mins_o,
  output logic [SECS_W-1:0]  secs_o,
  output logic [1:0]         mode_o,
  output logic               blink_o
);

  localparam int CNT_W = $clog2(TIMEOUT_S + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_S - 1);
  localparam logic [HOURS_W-1:0] H_TOP = HOURS_W'(HOURS_MAX);
  localparam logic [MINS_W-1:0]  M_TOP = MINS_W'(MINS_MAX);
  localparam logic [SECS_W-1:0]  S_TOP = SECS_W'(SECS_MAX);

  state_t             state_reg, state_next;
  logic [HOURS_W-1:0] hours_reg, hours_next, hours_adj;
  logic [MINS_W-1:0]  mins_reg, mins_next, mins_adj;
  logic [SECS_W-1:0]  secs_reg, secs_next, secs_adj;
  logic [CNT_W-1:0]   idle_reg, idle_next;
  logic               blink_reg, blink_next;
  logic               dec;

`ifdef CLOCK_SET_DEC_EN
  assign dec = btn_dec_i;
`else
  assign dec = 1'b0;
`endif

  // A mode press discards any simultaneous inc/dec.
  logic adj_en, any_btn;
  assign adj_en  = is_set(state_reg) && !btn_mode_i;
  assign any_btn = btn_mode_i || btn_inc_i || dec;

  field_adj #(.WIDTH(HOURS_W), .MAX(HOURS_MAX)) u_hours (
    .value(hours_reg), .inc(adj_en && state_reg == SET_HR && btn_inc_i),
    .dec(adj_en && state_reg == SET_HR && dec), .next_value(hours_adj)
  );
  field_adj #(.WIDTH(MINS_W), .MAX(MINS_MAX)) u_mins (
    .value(mins_reg), .inc(adj_en && state_reg == SET_MIN && btn_inc_i),
    .dec(adj_en && state_reg == SET_MIN && dec), .next_value(mins_adj)
  );
  field_adj #(.WIDTH(SECS_W), .MAX(SECS_MAX)) u_secs (
    .value(secs_reg), .inc(adj_en && state_reg == SET_SEC && btn_inc_i),
    .dec(adj_en && state_reg == SET_SEC && dec), .next_value(secs_adj)
  );

  always_comb begin
    state_next = state_reg;
    hours_next = hours_reg;
    mins_next  = mins_reg;
    secs_next  = secs_reg;
    idle_next  = idle_reg;
    blink_next = blink_reg;
    case (state_reg)
      RUN: begin
        idle_next  = '0;
        blink_next = 1'b0;
        if (btn_mode_i) begin
          hours_next = (hours_cur_i > H_TOP) ? '0 : hours_cur_i;
          mins_next  = (mins_cur_i > M_TOP) ? '0 : mins_cur_i;
          secs_next  = (secs_cur_i > S_TOP) ? '0 : secs_cur_i;
          state_next = SET_HR;
        end
      end
      SET_HR, SET_MIN, SET_SEC: begin
        hours_next = hours_adj;
        mins_next  = mins_adj;
        secs_next  = secs_adj;
        if (btn_mode_i) begin
          idle_next = '0;
          case (state_reg)
            SET_HR:  state_next = SET_MIN;
            SET_MIN: state_next = SET_SEC;
            default: state_next = COMMIT;
          endcase
          if (state_reg == SET_SEC) blink_next = 1'b0;
          else if (tick_i)          blink_next = !blink_reg;
        end else if (any_btn) begin
          // Keep the edited field lit right after an adjustment.
          idle_next  = '0;
          blink_next = 1'b0;
        end else if (tick_i) begin
          if (idle_reg == IDLE_LAST) begin
            state_next = RUN;
            idle_next  = '0;
            blink_next = 1'b0;
          end else begin
            idle_next  = idle_reg + 1'b1;
            blink_next = !blink_reg;
          end
        end
      end
      COMMIT: begin
        state_next = RUN;
        idle_next  = '0;
        blink_next = 1'b0;
      end
      default: begin
        state_next = RUN;
        idle_next  = '0;
        blink_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      hours_reg <= '0;
      mins_reg  <= '0;
      secs_reg  <= '0;
      idle_reg  <= '0;
      blink_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      hours_reg <= hours_next;
      mins_reg  <= mins_next;
      secs_reg  <= secs_next;
      idle_reg  <= idle_next;
      blink_reg <= blink_next;
    end
  end

  assign ld_o    = (state_reg == COMMIT);
  assign mode_o  = mode_code(state_reg);
  assign blink_o = blink_reg;
  assign hours_o = hours_reg;
  assign mins_o  = mins_reg;
  assign secs_o  = secs_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus randomized presses/ticks against a behavioural model.
module tb_clock_set_ctrl;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, bm = 1'b0, bi = 1'b0, bd = 1'b0;
  logic [4:0] hc = '0;
  logic [5:0] mc = '0, sc = '0;
  logic       ld, bl;
  logic [4:0] ho;
  logic [5:0] mo, so;
  logic [1:0] md;

  always #5 clk = ~clk;

  clock_set_ctrl #(.TIMEOUT_S(TO)) dut (
    .clk(clk),
    .reset(reset),
    .tick_i(tick),
    .btn_mode_i(bm),
    .btn_inc_i(bi),
`ifdef CLOCK_SET_DEC_EN
    .btn_dec_i(bd),
`endif
    .hours_cur_i(hc),
    .mins_cur_i(mc),
    .secs_cur_i(sc),
    .ld_o(ld),
    .hours_o(ho),
    .mins_o(mo),
    .secs_o(so),
    .mode_o(md),
    .blink_o(bl)
  );

  int checks = 0, errors = 0, ld_seen = 0, base = 0;
  bit cmp_en = 1'b0;

  // Model: st 0=RUN, 1..3=SET field, 4=COMMIT
  int m_st = 0, m_h = 0, m_m = 0, m_s = 0, m_idle = 0;
  bit m_bl = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    int st, h, mi, s, idle, d;
    bit b;
    st = m_st; h = m_h; mi = m_m; s = m_s; idle = m_idle; b = m_bl;
    if (st == 4) begin
      st = 0; idle = 0; b = 0;
    end else if (st == 0) begin
      if (bm) begin
        h  = (int'(hc) > 23) ? 0 : int'(hc);
        mi = (int'(mc) > 59) ? 0 : int'(mc);
        s  = (int'(sc) > 59) ? 0 : int'(sc);
        st = 1; idle = 0; b = 0;
      end
    end else if (bm) begin
      st = st + 1; idle = 0;
      b = (st == 4) ? 1'b0 : (tick ? !b : b);
    end else if (bi || bd) begin
      d = (bi ? 1 : 0) - (bd ? 1 : 0);
      case (st)
        1: h  = (h + d + 24) % 24;
        2: mi = (mi + d + 60) % 60;
        default: s = (s + d + 60) % 60;
      endcase
      idle = 0; b = 0;
    end else if (tick) begin
      idle = idle + 1;
      if (idle >= TO) begin
        st = 0; idle = 0; b = 0;
      end else begin
        b = !b;
      end
    end
    m_st <= st; m_h <= h; m_m <= mi; m_s <= s; m_idle <= idle; m_bl <= b;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st <= 0; m_h <= 0; m_m <= 0; m_s <= 0; m_idle <= 0; m_bl <= 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mode_o", md, (m_st == 4) ? 3 : m_st);
      chk("ld_o", ld, (m_st == 4) ? 1 : 0);
      chk("blink_o", bl, m_bl);
      chk("hours_o", ho, m_h);
      chk("mins_o", mo, m_m);
      chk("secs_o", so, m_s);
      if (ld === 1'b1) ld_seen++;
    end
  end

  task automatic cyc(input bit m, input bit i, input bit d, input bit t);
    bm = m; bi = i; bd = d; tick = t;
    @(negedge clk);
    bm = 0; bi = 0; bd = 0; tick = 0;
  endtask

  int pm, pi, pt;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mode", md, 0);
    chk("rst_ld", ld, 0);
    chk("rst_blink", bl, 0);
    chk("rst_hours", ho, 0);
    reset = 0;
    cmp_en = 1'b1;
    @(negedge clk);

    // Capture 13:45:07
    hc = 5'd13; mc = 6'd45; sc = 6'd7;
    cyc(1, 0, 0, 0);
    chk("cap_mode", md, 1);
    chk("cap_h", ho, 13); chk("cap_m", mo, 45); chk("cap_s", so, 7);

    // Blink toggles on ticks, cleared by inc
    cyc(0, 0, 0, 1); chk("blink_t1", bl, 1);
    cyc(0, 0, 0, 1); chk("blink_t2", bl, 0);
    cyc(0, 0, 0, 1); chk("blink_t3", bl, 1);
    cyc(0, 1, 0, 0); chk("blink_inc", bl, 0); chk("inc_h14", ho, 14);

    // Hour and minute wrap
    repeat (9) cyc(0, 1, 0, 0);
    chk("h23", ho, 23);
    cyc(0, 1, 0, 0); chk("h_wrap", ho, 0);
    cyc(1, 0, 0, 0); chk("to_min", md, 2);
    repeat (14) cyc(0, 1, 0, 0);
    chk("m59", mo, 59);
    cyc(0, 1, 0, 0); chk("m_wrap", mo, 0); chk("m_wrap_h", ho, 0);

    // Commit
    cyc(1, 0, 0, 0); chk("to_sec", md, 3);
    base = ld_seen;
    cyc(1, 0, 0, 0);
    chk("commit_ld", ld, 1); chk("commit_mode", md, 3);
    chk("commit_h", ho, 0); chk("commit_m", mo, 0); chk("commit_s", so, 7);
    cyc(0, 0, 0, 0);
    chk("post_commit_mode", md, 0); chk("post_commit_ld", ld, 0);
    chk("ld_count", ld_seen - base, 1);

    // Timeout in SET_MIN
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    base = ld_seen;
    repeat (9) cyc(0, 0, 0, 1);
    chk("to_9", md, 2);
    cyc(0, 0, 0, 1); chk("to_10", md, 0);
    cyc(0, 0, 0, 0); chk("to_no_ld", ld_seen - base, 0);

    // Inc on the 10th tick wins over timeout
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    repeat (9) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    chk("inc_tick_mode", md, 2); chk("inc_tick_m", mo, 46);
    repeat (9) cyc(0, 0, 0, 1);
    chk("rearm_9", md, 2);
    cyc(0, 0, 0, 1); chk("rearm_10", md, 0);

    // Out-of-range capture, mode+inc together
    hc = 5'd24;
    cyc(1, 0, 0, 0); chk("oor_h", ho, 0); chk("oor_mode", md, 1);
    cyc(1, 1, 0, 0); chk("mi_mode", md, 2); chk("mi_h", ho, 0); chk("mi_m", mo, 45);

    // Reset mid SET_SEC
    cyc(1, 0, 0, 0); chk("pre_rst_mode", md, 3);
    base = ld_seen;
    reset = 1;
    #1;
    chk("rst_mid_mode", md, 0); chk("rst_mid_ld", ld, 0); chk("rst_mid_s", so, 0);
    @(negedge clk);
    reset = 0;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("rst_no_ld", ld_seen - base, 0); chk("rst_run", md, 0);

`ifdef CLOCK_SET_DEC_EN
    hc = 5'd13; sc = 6'd0;
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("dec_sec_mode", md, 3);
    cyc(0, 0, 1, 0); chk("dec_wrap", so, 59);
    cyc(0, 1, 1, 0); chk("incdec", so, 59);
    cyc(1, 0, 1, 0); chk("mode_beats_dec", md, 3); chk("mode_beats_dec_ld", ld, 1);
    cyc(0, 0, 0, 0);
`endif

    // Randomized phase
    pm = 5; pi = 10; pt = 20;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) begin
        pm = $urandom_range(0, 15);
        pi = $urandom_range(0, 30);
        pt = $urandom_range(5, 60);
      end
      hc = 5'($urandom_range(0, 31));
      mc = 6'($urandom_range(0, 63));
      sc = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 499) == 0) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
      end else begin
`ifdef CLOCK_SET_DEC_EN
        cyc($urandom_range(0, 99) < pm, $urandom_range(0, 99) < pi,
            $urandom_range(0, 99) < pi, $urandom_range(0, 99) < pt);
`else
        cyc($urandom_range(0, 99) < pm, $urandom_range(0, 99) < pi,
            1'b0, $urandom_range(0, 99) < pt);
`endif
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
